// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - Operand read, write-back and load-scoreboard bundle
interface reg_file_sb_if #(
   parameter int WIDTH = 32
) ();
   logic [4:0]       ra;
   logic [4:0]       rb;
   logic             use_a;
   logic             use_b;
   logic [WIDTH-1:0] busA;
   logic [WIDTH-1:0] busB;
   logic [4:0]       rw;
   logic [WIDTH-1:0] busW;
   logic             RegWr;
   logic             set_busy;
   logic [4:0]       busy_rw;
   logic             stall;
   logic [31:0]      busy_vec;
   logic [5:0]       pend_cnt;

   modport master (
      output ra, rb, use_a, use_b, rw, busW, RegWr, set_busy, busy_rw,
      input  busA, busB, stall, busy_vec, pend_cnt
   );

   modport slave (
      input  ra, rb, use_a, use_b, rw, busW, RegWr, set_busy, busy_rw,
      output busA, busB, stall, busy_vec, pend_cnt
   );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - Minisys register file with write-through bypass and load scoreboard
module reg_file_sb #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   reg_file_sb_if.slave  bus
);
   logic [WIDTH-1:0] r_regs [1:31];
   logic [31:0]      r_busy;
   logic [5:0]       r_pend_cnt;

   logic [31:0]      w_set_vec;
   logic [31:0]      w_clr_vec;
   logic [31:0]      w_busy_nxt;
   logic             w_inc;
   logic             w_dec;
   logic             w_byp_a;
   logic             w_byp_b;
   logic             w_pend_a;
   logic             w_pend_b;

   // Set is applied after clear so a new load supersedes a retiring write.
   always_comb begin
      w_set_vec = '0;
      w_clr_vec = '0;
      if (bus.set_busy) w_set_vec[bus.busy_rw] = 1'b1;
      if (bus.RegWr)    w_clr_vec[bus.rw]      = 1'b1;
      w_set_vec[0] = 1'b0;
      w_clr_vec[0] = 1'b0;
      w_busy_nxt = (r_busy & ~w_clr_vec) | w_set_vec;
      w_inc = |(w_set_vec & ~r_busy);
      w_dec = |(w_clr_vec & r_busy & ~w_set_vec);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < 32; i++) r_regs[i] <= '0;
      end else if (bus.RegWr && bus.rw != 5'd0) begin
         r_regs[bus.rw] <= bus.busW;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy     <= '0;
         r_pend_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_pend_cnt <= r_pend_cnt + {5'd0, w_inc} - {5'd0, w_dec};
      end
   end

   assign w_byp_a = bus.RegWr && (bus.rw == bus.ra);
   assign w_byp_b = bus.RegWr && (bus.rw == bus.rb);

   assign bus.busA = (bus.ra == 5'd0) ? '0 : (w_byp_a ? bus.busW : r_regs[bus.ra]);
   assign bus.busB = (bus.rb == 5'd0) ? '0 : (w_byp_b ? bus.busW : r_regs[bus.rb]);

   // A register retiring this cycle is served by the bypass, so it does not stall.
   assign w_pend_a = r_busy[bus.ra] && !w_byp_a;
   assign w_pend_b = r_busy[bus.rb] && !w_byp_b;

   assign bus.stall    = (bus.use_a && bus.ra != 5'd0 && w_pend_a) ||
                         (bus.use_b && bus.rb != 5'd0 && w_pend_b);
   assign bus.busy_vec = r_busy;
   assign bus.pend_cnt = r_pend_cnt;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - Self-checking bench for reg_file_sb against a behavioural model
module tb_reg_file_sb;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_file_sb_if #(.WIDTH(32)) rf ();
   reg_file_sb #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(rf));

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_regs [32];
   bit          m_busy [32];

   function automatic logic [31:0] m_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   function automatic logic [5:0] m_cnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
      return 6'(c);
   endfunction

   function automatic logic [31:0] m_read(logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (rf.RegWr && rf.rw == r) return rf.busW;
      return m_regs[r];
   endfunction

   function automatic logic m_stall();
      logic pa, pb;
      pa = rf.use_a && rf.ra != 5'd0 && m_busy[rf.ra] && !(rf.RegWr && rf.rw == rf.ra);
      pb = rf.use_b && rf.rb != 5'd0 && m_busy[rf.rb] && !(rf.RegWr && rf.rw == rf.rb);
      return pa || pb;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'd0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic idle();
      rf.ra = 5'd0; rf.rb = 5'd0; rf.use_a = 1'b0; rf.use_b = 1'b0;
      rf.rw = 5'd0; rf.busW = 32'd0; rf.RegWr = 1'b0;
      rf.set_busy = 1'b0; rf.busy_rw = 5'd0;
   endtask

   // One clock edge; the model applies the held inputs the way the block is described.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         if (rf.RegWr && rf.rw != 5'd0) begin
            m_regs[rf.rw] = rf.busW;
            m_busy[rf.rw] = 1'b0;
         end
         if (rf.set_busy && rf.busy_rw != 5'd0) m_busy[rf.busy_rw] = 1'b1;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      rf.ra = 5'd5; rf.rb = 5'd31; rf.use_a = 1'b1; rf.use_b = 1'b1;
      #1;
      n_cmp++; if (rf.busA !== 32'd0) begin n_err++; $display("FAIL reset_busA got %h exp 0", rf.busA); end
      n_cmp++; if (rf.busB !== 32'd0) begin n_err++; $display("FAIL reset_busB got %h exp 0", rf.busB); end
      n_cmp++; if (rf.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", rf.stall); end
      n_cmp++; if (rf.pend_cnt !== 6'd0) begin n_err++; $display("FAIL reset_pend got %0d exp 0", rf.pend_cnt); end
      n_cmp++; if (rf.busy_vec !== 32'd0) begin n_err++; $display("FAIL reset_busy got %h exp 0", rf.busy_vec); end
      tick();
      rst = 1'b0;
      m_reset();
      idle();
   endtask

   task automatic test_write_read();
      rf.RegWr = 1'b1; rf.rw = 5'd7; rf.busW = 32'hDEADBEEF; rf.ra = 5'd7;
      #1;
      n_cmp++; if (rf.busA !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_busA got %h exp deadbeef", rf.busA); end
      tick();
      rf.RegWr = 1'b0;
      #1;
      n_cmp++; if (rf.busA !== 32'hDEADBEEF) begin n_err++; $display("FAIL stored_busA got %h exp deadbeef", rf.busA); end
      rf.RegWr = 1'b1; rf.rw = 5'd0; rf.busW = 32'h1234; rf.ra = 5'd0; rf.rb = 5'd0;
      #1;
      n_cmp++; if (rf.busA !== 32'd0) begin n_err++; $display("FAIL r0_bypass_busA got %h exp 0", rf.busA); end
      n_cmp++; if (rf.busB !== 32'd0) begin n_err++; $display("FAIL r0_bypass_busB got %h exp 0", rf.busB); end
      tick();
      idle();
      rf.rb = 5'd7;
      #1;
      n_cmp++; if (rf.busA !== 32'd0) begin n_err++; $display("FAIL r0_stored_busA got %h exp 0", rf.busA); end
      n_cmp++; if (rf.busB !== 32'hDEADBEEF) begin n_err++; $display("FAIL r7_busB got %h exp deadbeef", rf.busB); end
      idle();
   endtask

   task automatic test_load_use();
      rf.set_busy = 1'b1; rf.busy_rw = 5'd9;
      tick();
      idle();
      rf.ra = 5'd9; rf.use_a = 1'b1;
      #1;
      n_cmp++; if (rf.stall !== 1'b1) begin n_err++; $display("FAIL load_use_stall got %b exp 1", rf.stall); end
      n_cmp++; if (rf.busy_vec !== 32'h200) begin n_err++; $display("FAIL load_use_busy got %h exp 200", rf.busy_vec); end
      n_cmp++; if (rf.pend_cnt !== 6'd1) begin n_err++; $display("FAIL load_use_pend got %0d exp 1", rf.pend_cnt); end
      rf.use_a = 1'b0;
      #1;
      n_cmp++; if (rf.stall !== 1'b0) begin n_err++; $display("FAIL unused_stall got %b exp 0", rf.stall); end
      rf.ra = 5'd0; rf.rb = 5'd9; rf.use_b = 1'b1;
      #1;
      n_cmp++; if (rf.stall !== 1'b1) begin n_err++; $display("FAIL load_use_b_stall got %b exp 1", rf.stall); end
      idle();
   endtask

   task automatic test_retire_bypass();
      rf.RegWr = 1'b1; rf.rw = 5'd9; rf.busW = 32'h55; rf.ra = 5'd9; rf.use_a = 1'b1;
      #1;
      n_cmp++; if (rf.stall !== 1'b0) begin n_err++; $display("FAIL retire_stall got %b exp 0", rf.stall); end
      n_cmp++; if (rf.busA !== 32'h55) begin n_err++; $display("FAIL retire_busA got %h exp 55", rf.busA); end
      tick();
      idle();
      #1;
      n_cmp++; if (rf.busy_vec !== 32'd0) begin n_err++; $display("FAIL retire_busy got %h exp 0", rf.busy_vec); end
      n_cmp++; if (rf.pend_cnt !== 6'd0) begin n_err++; $display("FAIL retire_pend got %0d exp 0", rf.pend_cnt); end
   endtask

   task automatic test_set_clear_same();
      rf.set_busy = 1'b1; rf.busy_rw = 5'd3;
      tick();
      rf.RegWr = 1'b1; rf.rw = 5'd3; rf.busW = 32'hA5A5_0003;
      tick();
      idle();
      rf.ra = 5'd3; rf.rb = 5'd3; rf.use_b = 1'b1;
      #1;
      n_cmp++; if (rf.busA !== 32'hA5A5_0003) begin n_err++; $display("FAIL setclr_busA got %h exp a5a50003", rf.busA); end
      n_cmp++; if (rf.busy_vec !== 32'h8) begin n_err++; $display("FAIL setclr_busy got %h exp 8", rf.busy_vec); end
      n_cmp++; if (rf.pend_cnt !== 6'd1) begin n_err++; $display("FAIL setclr_pend got %0d exp 1", rf.pend_cnt); end
      n_cmp++; if (rf.stall !== 1'b1) begin n_err++; $display("FAIL setclr_stall got %b exp 1", rf.stall); end
      idle();
   endtask

   task automatic test_async_reset();
      rf.RegWr = 1'b1; rf.rw = 5'd4; rf.busW = 32'h77;
      rf.set_busy = 1'b1; rf.busy_rw = 5'd1;
      tick();
      idle();
      rf.set_busy = 1'b1; rf.busy_rw = 5'd2;
      tick();
      rf.busy_rw = 5'd8;
      tick();
      idle();
      #1;
      n_cmp++; if (rf.busy_vec !== 32'h0000_010E) begin n_err++; $display("FAIL pre_rst_busy got %h exp 0000010e", rf.busy_vec); end
      n_cmp++; if (rf.pend_cnt !== 6'd4) begin n_err++; $display("FAIL pre_rst_pend got %0d exp 4", rf.pend_cnt); end
      rf.RegWr = 1'b1; rf.rw = 5'd3;
      tick();
      idle();
      #1;
      n_cmp++; if (rf.busy_vec !== 32'h0000_0106) begin n_err++; $display("FAIL pre_rst_busy2 got %h exp 00000106", rf.busy_vec); end
      n_cmp++; if (rf.pend_cnt !== 6'd3) begin n_err++; $display("FAIL pre_rst_pend2 got %0d exp 3", rf.pend_cnt); end
      rf.ra = 5'd4;
      rst = 1'b1;
      #1;
      n_cmp++; if (rf.busy_vec !== 32'd0) begin n_err++; $display("FAIL async_busy got %h exp 0", rf.busy_vec); end
      n_cmp++; if (rf.pend_cnt !== 6'd0) begin n_err++; $display("FAIL async_pend got %0d exp 0", rf.pend_cnt); end
      n_cmp++; if (rf.busA !== 32'd0) begin n_err++; $display("FAIL async_busA got %h exp 0", rf.busA); end
      rf.RegWr = 1'b1; rf.rw = 5'd4; rf.busW = 32'h99;
      rf.set_busy = 1'b1; rf.busy_rw = 5'd6;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      idle();
      rf.ra = 5'd4;
      #1;
      n_cmp++; if (rf.busA !== 32'd0) begin n_err++; $display("FAIL rst_write_lost got %h exp 0", rf.busA); end
      n_cmp++; if (rf.busy_vec !== 32'd0) begin n_err++; $display("FAIL rst_set_lost got %h exp 0", rf.busy_vec); end
      rf.RegWr = 1'b1; rf.rw = 5'd4; rf.busW = 32'hCAFE;
      tick();
      rf.RegWr = 1'b0;
      #1;
      n_cmp++; if (rf.busA !== 32'hCAFE) begin n_err++; $display("FAIL post_rst_write got %h exp cafe", rf.busA); end
      idle();
   endtask

   function automatic logic [4:0] rand_reg();
      if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rf.ra = rand_reg(); rf.rb = rand_reg(); rf.rw = rand_reg(); rf.busy_rw = rand_reg();
         rf.use_a = 1'($urandom_range(0, 1));
         rf.use_b = 1'($urandom_range(0, 1));
         rf.RegWr = 1'($urandom_range(0, 1));
         rf.set_busy = ($urandom_range(0, 2) == 0);
         rf.busW = $urandom;
         #1;
         n_cmp++; if (rf.busA !== m_read(rf.ra)) begin n_err++; $display("FAIL rnd_busA[%0d] got %h exp %h", n, rf.busA, m_read(rf.ra)); end
         n_cmp++; if (rf.busB !== m_read(rf.rb)) begin n_err++; $display("FAIL rnd_busB[%0d] got %h exp %h", n, rf.busB, m_read(rf.rb)); end
         n_cmp++; if (rf.stall !== m_stall()) begin n_err++; $display("FAIL rnd_stall[%0d] got %b exp %b", n, rf.stall, m_stall()); end
         n_cmp++; if (rf.busy_vec !== m_vec()) begin n_err++; $display("FAIL rnd_busy[%0d] got %h exp %h", n, rf.busy_vec, m_vec()); end
         n_cmp++; if (rf.pend_cnt !== m_cnt()) begin n_err++; $display("FAIL rnd_pend[%0d] got %0d exp %0d", n, rf.pend_cnt, m_cnt()); end
         n_cmp++; if (rf.pend_cnt !== 6'($countones(rf.busy_vec))) begin n_err++; $display("FAIL rnd_popcount[%0d] got %0d exp %0d", n, rf.pend_cnt, $countones(rf.busy_vec)); end
         tick();
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      m_reset();
      test_reset();
      test_write_read();
      test_load_use();
      test_retire_bypass();
      test_set_clear_same();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
